dcache_sa_controller: RTL

Parametrised, set-associative, write-back/write-allocate L1 data-cache controller that sits between the EX/MEM pipeline register and the 256-bit external data memory. It is the successor to the direct-mapped controller: associativity and set count are configurable, a per-set round-robin victim pointer is added, and optional hit/miss counters are available. It serves one 32-bit load/store per request and freezes the pipeline via `cpu_stall_o` during refills.

---
 rtl/dcache_sa_controller.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_sa_controller.sv
// dcache_sa_controller
// Set-associative, write-back / write-allocate L1 data-cache controller placed
// between the EX/MEM pipeline register and a 256-bit external data memory.
// It serves one 32-bit load/store per request. On a miss it freezes the
// pipeline, writes back a dirty victim if needed, refills the line and then
// replays the request as a hit.
//
// Parameters
//   WAYS   : associativity (1, 2 or 4)
//   SETS   : sets per way (power of two, 2..64)
//   LINE_W : line width in bits (8 words of 32 bits)
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   rst_i          : asynchronous active-low reset
//   cpu_addr_i     : byte address (offset [4:0], word [4:2], index, tag)
//   cpu_data_i     : store data
//   cpu_MemRead_i  : load request
//   cpu_MemWrite_i : store request (wins when both are asserted)
//   cpu_data_o     : load data, combinational on a hit
//   cpu_stall_o    : pipeline freeze while a miss is being serviced
//   mem_data_i     : refill line
//   mem_ack_i      : one-cycle completion pulse from memory
//   mem_data_o     : victim line during write-back
//   mem_addr_o     : line-aligned memory address
//   mem_enable_o   : memory request
//   mem_write_o    : 1 = write-back, 0 = refill
//
// Optional feature (macro DCACHE_SA_PERF_CNT_EN)
//   hit_cnt_o  : saturating count of IDLE hit cycles
//   miss_cnt_o : saturating count of misses leaving IDLE
module dcache_sa_controller #(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
`ifdef DCACHE_SA_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 27 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Replace one 32-bit word of a line, keeping all other bytes.
  function automatic logic [LINE_W-1:0] merge_word(
    input logic [LINE_W-1:0] line,
    input logic [2:0]        sel,
    input logic [31:0]       data
  );
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[{sel, 5'b00000} +: 32] = data;
    return merged;
  endfunction

  // Storage arrays
  logic [WAYS-1:0]   valid_r [SETS];
  logic [WAYS-1:0]   dirty_r [SETS];
  logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
  logic [LINE_W-1:0] line_r  [SETS][WAYS];

  state_t            state_r;
  state_t            state_s;
  logic [WAY_W-1:0]  victim_way_r;

  // Address decode
  logic [2:0]        word_sel_s;
  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic              unused_addr_s;

  assign word_sel_s    = cpu_addr_i[4:2];
  assign idx_s         = cpu_addr_i[5 +: IDX_W];
  assign tag_s         = cpu_addr_i[31 -: TAG_W];
  assign unused_addr_s = ^cpu_addr_i[1:0];

  // Lookup results
  logic [WAYS-1:0]   hit_vec_s;
  logic              hit_s;
  logic [WAY_W-1:0]  hit_way_s;
  logic [WAY_W-1:0]  inv_way_s;
  logic              all_valid_s;
  logic [WAY_W-1:0]  vptr_s;
  logic [WAY_W-1:0]  miss_victim_s;

  // Control
  logic              req_s;
  logic              in_serve_s;
  logic              miss_s;
  logic              store_we_s;
  logic              refill_done_s;
  logic              victim_dirty_s;
  logic [TAG_W-1:0]  victim_tag_s;
  logic [LINE_W-1:0] victim_line_s;

  assign req_s      = cpu_MemRead_i | cpu_MemWrite_i;
  // Requests are answered from the arrays in IDLE and in the replay cycle.
  assign in_serve_s = (state_r == IDLE) || (state_r == DONE);

  // Tag compare across ways; descending scan so the lowest way wins.
  always_comb begin
    hit_vec_s = {WAYS{1'b0}};
    hit_way_s = {WAY_W{1'b0}};
    inv_way_s = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec_s[w] = valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s);
      hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
      inv_way_s    = (!valid_r[idx_s][w]) ? WAY_W'(w) : inv_way_s;
    end
    hit_s         = |hit_vec_s;
    all_valid_s   = &valid_r[idx_s];
    miss_victim_s = all_valid_s ? vptr_s : inv_way_s;
  end

  generate
    if (WAYS > 1) begin : g_vptr
      logic [WAY_W-1:0] vptr_r [SETS];

      // Per-set round-robin pointer, advanced on every completed refill.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          for (int s = 0; s < SETS; s++) begin
            vptr_r[s] <= {WAY_W{1'b0}};
          end
        end else if (refill_done_s) begin
          vptr_r[idx_s] <= vptr_r[idx_s] + WAY_W'(1);
        end
      end

      assign vptr_s = vptr_r[idx_s];
    end else begin : g_no_vptr
      assign vptr_s = {WAY_W{1'b0}};
    end
  endgenerate

  assign miss_s         = (state_r == IDLE) && req_s && !hit_s;
  assign store_we_s     = cpu_MemWrite_i && hit_s && in_serve_s;
  assign refill_done_s  = (state_r == REFILL) && mem_ack_i;
  assign victim_dirty_s = valid_r[idx_s][miss_victim_s] && dirty_r[idx_s][miss_victim_s];
  assign victim_tag_s   = tag_r[idx_s][victim_way_r];
  assign victim_line_s  = line_r[idx_s][victim_way_r];

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; acks outside WB/REFILL are ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          state_s = victim_dirty_s ? WB : REFILL;
        end else begin
          state_s = IDLE;
        end
      end
      WB: begin
        if (mem_ack_i) begin
          state_s = REFILL;
        end else begin
          state_s = WB;
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          state_s = DONE;
        end else begin
          state_s = REFILL;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Victim chosen when the miss is detected, held for WB and REFILL.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      victim_way_r <= {WAY_W{1'b0}};
    end else if (miss_s) begin
      victim_way_r <= miss_victim_s;
    end
  end

  // Valid/dirty bookkeeping: refill installs a clean line, store marks dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        dirty_r[s] <= {WAYS{1'b0}};
      end
    end else if (refill_done_s) begin
      valid_r[idx_s][victim_way_r] <= 1'b1;
      dirty_r[idx_s][victim_way_r] <= 1'b0;
    end else if (store_we_s) begin
      dirty_r[idx_s][hit_way_s] <= 1'b1;
    end
  end

  // Tag and data arrays; contents only matter behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (refill_done_s) begin
      line_r[idx_s][victim_way_r] <= mem_data_i;
      tag_r[idx_s][victim_way_r]  <= tag_s;
    end else if (store_we_s) begin
      line_r[idx_s][hit_way_s] <= merge_word(line_r[idx_s][hit_way_s], word_sel_s, cpu_data_i);
    end
  end

  // CPU side: forced low while reset is held.
  assign cpu_data_o  = (rst_i && req_s && hit_s && in_serve_s)
                     ? line_r[idx_s][hit_way_s][{word_sel_s, 5'b00000} +: 32]
                     : 32'h0000_0000;
  assign cpu_stall_o = rst_i && (miss_s || (state_r == WB) || (state_r == REFILL));

  // Memory side: driven only in the two transfer states.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0000_0000;
    mem_data_o   = {LINE_W{1'b0}};
    case (state_r)
      WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {victim_tag_s, idx_s, 5'b00000};
        mem_data_o   = victim_line_s;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b0;
        mem_addr_o   = {tag_s, idx_s, 5'b00000};
        mem_data_o   = {LINE_W{1'b0}};
      end
      IDLE, DONE: begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0000_0000;
        mem_data_o   = {LINE_W{1'b0}};
      end
      default: begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0000_0000;
        mem_data_o   = {LINE_W{1'b0}};
      end
    endcase
  end

`ifdef DCACHE_SA_PERF_CNT_EN
  logic hit_evt_s;

  assign hit_evt_s = (state_r == IDLE) && req_s && hit_s;

  // Saturating hit/miss counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= 32'h0000_0000;
      miss_cnt_o <= 32'h0000_0000;
    end else begin
      if (hit_evt_s && (hit_cnt_o != 32'hFFFF_FFFF)) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (miss_s && (miss_cnt_o != 32'hFFFF_FFFF)) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
